// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
//   Shared definitions for the display datapath (binary-to-BCD converter and
//   the 7-segment scanner that consumes its output).
//   NUM_DIGITS : digits shown on the display (packed BCD output width / 4)
//   INT_DIGITS : digits held in the converter accumulator (65535 needs 5)
//   BLANK_CODE : nibble value the segment decoder renders as all-off
//   state_t    : converter FSM encoding; the unused code 2'd3 recovers to IDLE
// ---------------------------------------------------------------------------
package disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int INT_DIGITS = 5;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/disp_bin2bcd_if.sv
// ---------------------------------------------------------------------------
// disp_bin2bcd_if
//   Request/result bundle between a CPU-side producer and the binary-to-BCD
//   converter.
//   start   : conversion request (producer -> converter)
//   bin_in  : unsigned binary value, DATA_W bits (producer -> converter)
//   bcd_out : packed BCD {thousands,hundreds,tens,ones} (converter -> display)
//   busy    : conversion in progress
//   done    : one-cycle pulse, bcd_out/ovf valid from this cycle on
//   ovf     : value exceeded 9999, bcd_out shows value mod 10000
//   master modport: producer side; slave modport: converter side.
// ---------------------------------------------------------------------------
interface disp_bin2bcd_if #(
  parameter int DATA_W = 16
);

  logic              start;
  logic [DATA_W-1:0] bin_in;
  logic [15:0]       bcd_out;
  logic              busy;
  logic              done;
  logic              ovf;

  modport master (
    output start, bin_in,
    input  bcd_out, busy, done, ovf
  );

  modport slave (
    input  start, bin_in,
    output bcd_out, busy, done, ovf
  );

endinterface

// File: rtl/disp_bin2bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
//   Combinational double-dabble correction cell: a BCD nibble of 5 or more
//   gets +3 so that the following left shift carries correctly into the next
//   decimal digit.
//   din  : nibble before correction (legal values 0..9)
//   dout : corrected nibble (0..4 unchanged, 5..9 -> 8..12)
// ---------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/disp_bin2bcd.sv
// ---------------------------------------------------------------------------
// disp_bin2bcd
//   Sequential binary-to-BCD converter (shift-add-3 / double dabble) feeding
//   the 4-digit 7-segment scanner. One bit is shifted per clock; the result
//   register is updated in a single cycle at the end, so the display never
//   shows a partially converted value.
//
//   Parameters
//     DATA_W : width of bin_in, 1..16 (zero-extended internally)
//   Ports
//     clk    : system clock, all state changes on posedge
//     rst    : asynchronous active-high reset, aborts any conversion
//     bus    : disp_bin2bcd_if.slave (start, bin_in, bcd_out, busy, done, ovf)
//
//   Timing: start accepted at edge E0 (only while idle), shifts on edges
//   E0+1..E0+DATA_W, result written on edge E0+DATA_W+1 together with a
//   one-cycle done pulse. A start during the done cycle is accepted, giving
//   back-to-back conversions every DATA_W+2 cycles.
//
//   Build option: define BIN2BCD_LEAD_ZERO_BLANK_EN to replace leading zero
//   digits (thousands/hundreds/tens, MS side first, stopping at the first
//   non-zero digit) with BLANK_CODE. The ones digit is never blanked, and no
//   blanking is applied when ovf is set.
// ---------------------------------------------------------------------------
module disp_bin2bcd
  import disp_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  disp_bin2bcd_if.slave bus
);

  localparam int ACC_W = 4 * INT_DIGITS;
  localparam int OUT_W = 4 * NUM_DIGITS;
  localparam logic [4:0] LAST_CNT = 5'(DATA_W - 1);

  state_t state_reg, state_next;

  logic [ACC_W-1:0]  acc_reg;
  logic [DATA_W-1:0] shreg_reg;
  logic [4:0]        cnt_reg;
  logic [OUT_W-1:0]  bcd_out_reg;
  logic              ovf_reg;
  logic              busy_reg;
  logic              done_reg;

  logic load_en, shift_en, finish_en;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = bus.start ? SHIFT : IDLE;
      SHIFT:   state_next = (cnt_reg == LAST_CNT) ? DONE : SHIFT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: datapath strobes
  // -------------------------------------------------------------------------
  always_comb begin
    load_en   = 1'b0;
    shift_en  = 1'b0;
    finish_en = 1'b0;
    case (state_reg)
      IDLE:    load_en   = bus.start;
      SHIFT:   shift_en  = 1'b1;
      DONE:    finish_en = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Add-3 correction on every accumulator digit, all in parallel, using the
  // pre-shift value.
  // -------------------------------------------------------------------------
  logic [ACC_W-1:0] acc_corr;

  genvar gi;
  generate
    for (gi = 0; gi < INT_DIGITS; gi++) begin : g_add3
      bcd_add3 u_add3 (
        .din  (acc_reg[4*gi +: 4]),
        .dout (acc_corr[4*gi +: 4])
      );
    end
  endgenerate

  // The top corrected bit is shifted out of the accumulator; with at most 16
  // input bits the fifth digit never reaches 8, so nothing is lost.
  logic acc_unused_msb;
  assign acc_unused_msb = acc_corr[ACC_W-1];

  // -------------------------------------------------------------------------
  // Result formatting (optional leading-zero blanking)
  // -------------------------------------------------------------------------
  logic             acc_ovf;
  logic [OUT_W-1:0] result;

  assign acc_ovf = (acc_reg[ACC_W-1:OUT_W] != '0);

`ifdef BIN2BCD_LEAD_ZERO_BLANK_EN
  always_comb begin
    result = acc_reg[OUT_W-1:0];
    if (!acc_ovf) begin
      if (result[15:12] == 4'd0) begin
        result[15:12] = BLANK_CODE;
        if (result[11:8] == 4'd0) begin
          result[11:8] = BLANK_CODE;
          if (result[7:4] == 4'd0) begin
            result[7:4] = BLANK_CODE;
          end
        end
      end
    end
  end
`else
  assign result = acc_reg[OUT_W-1:0];
`endif

  // -------------------------------------------------------------------------
  // Shift register, accumulator and counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg   <= '0;
      shreg_reg <= '0;
      cnt_reg   <= '0;
    end else if (load_en) begin
      acc_reg   <= '0;
      shreg_reg <= bus.bin_in;
      cnt_reg   <= '0;
    end else if (shift_en) begin
      acc_reg   <= {acc_corr[ACC_W-2:0], shreg_reg[DATA_W-1]};
      shreg_reg <= shreg_reg << 1;
      cnt_reg   <= cnt_reg + 5'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Output registers: bcd_out/ovf only change on the DONE edge
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_out_reg <= '0;
      ovf_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      // busy follows the state being entered, so an illegal state code
      // cannot leave it stuck high.
      busy_reg <= (state_next == SHIFT) || (state_next == DONE);
      done_reg <= finish_en;
      if (finish_en) begin
        bcd_out_reg <= result;
        ovf_reg     <= acc_ovf;
      end
    end
  end

  assign bus.bcd_out = bcd_out_reg;
  assign bus.ovf     = ovf_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_disp_bin2bcd.sv
// ---------------------------------------------------------------------------
// tb_disp_bin2bcd
//   Directed self-checking bench for disp_bin2bcd (DATA_W=16). Expected
//   values are hand-computed; the blanked column applies when the bench is
//   built with BIN2BCD_LEAD_ZERO_BLANK_EN.
// ---------------------------------------------------------------------------
module tb_disp_bin2bcd;

`ifdef BIN2BCD_LEAD_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  disp_bin2bcd_if #(.DATA_W(16)) bus ();

  disp_bin2bcd #(.DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [15:0] v;
    logic [15:0] plain;
    logic [15:0] blank;
    logic        ov;
  } vec_t;

  vec_t vecs [9] = '{
    '{16'd0,     16'h0000, 16'hFFF0, 1'b0},
    '{16'd1234,  16'h1234, 16'h1234, 1'b0},
    '{16'd9999,  16'h9999, 16'h9999, 1'b0},
    '{16'd10000, 16'h0000, 16'h0000, 1'b1},
    '{16'd65535, 16'h5535, 16'h5535, 1'b1},
    '{16'd7,     16'h0007, 16'hFFF7, 1'b0},
    '{16'd305,   16'h0305, 16'hF305, 1'b0},
    '{16'd12345, 16'h2345, 16'h2345, 1'b1},
    '{16'd5678,  16'h5678, 16'h5678, 1'b0}
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) at negedges for done; returns the cycle count or -1.
  task automatic wait_done(output int at, output int busy_cnt);
    at = -1;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        at = cyc;
        break;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
  endtask

  // Pulses start for one edge, returns with the cycle count of that edge.
  task automatic pulse_start(input logic [15:0] v, output int e0);
    @(negedge clk);
    bus.bin_in = v;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    e0 = cyc;
  endtask

  initial begin
    int e0, at, bc, d1;
    logic [15:0] exp;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_bcd",  bus.bcd_out, 16'h0000);
    check("rst_busy", bus.busy,    1'b0);
    check("rst_done", bus.done,    1'b0);
    check("rst_ovf",  bus.ovf,     1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed conversions
    for (int i = 0; i < 9; i++) begin
      pulse_start(vecs[i].v, e0);
      wait_done(at, bc);
      exp = BLANK ? vecs[i].blank : vecs[i].plain;
      check($sformatf("lat_%0d", vecs[i].v),  at - e0,     17);
      check($sformatf("busy_%0d", vecs[i].v), bc,          17);
      check($sformatf("bcd_%0d", vecs[i].v),  bus.bcd_out, exp);
      check($sformatf("ovf_%0d", vecs[i].v),  bus.ovf,     vecs[i].ov);
      check($sformatf("busy_at_done_%0d", vecs[i].v), bus.busy, 1'b0);
      @(negedge clk);
      check($sformatf("done_pulse_%0d", vecs[i].v), bus.done, 1'b0);
      $display("conv %0d -> bcd=%h ovf=%0d latency=%0d", vecs[i].v, bus.bcd_out, bus.ovf, at - e0);
    end

    // Start during a conversion is ignored; outputs hold meanwhile
    pulse_start(16'd1234, e0);
    repeat (3) @(negedge clk);
    bus.bin_in = 16'd42;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    check("hold_bcd", bus.bcd_out, BLANK ? 16'h5678 : 16'h5678);
    check("hold_busy", bus.busy, 1'b1);
    wait_done(at, bc);
    check("ign_lat", at - e0, 17);
    check("ign_bcd", bus.bcd_out, 16'h1234);
    $display("ignored start -> bcd=%h", bus.bcd_out);

    // Start in the done cycle is accepted: second done 18 cycles later
    d1 = cyc;
    bus.bin_in = 16'd42;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    wait_done(at, bc);
    check("b2b_gap", at - d1, 18);
    check("b2b_bcd", bus.bcd_out, BLANK ? 16'hFF42 : 16'h0042);
    check("b2b_ovf", bus.ovf, 1'b0);
    $display("back-to-back 42 -> bcd=%h gap=%0d", bus.bcd_out, at - d1);

    // Asynchronous reset at shift 8 aborts the conversion
    pulse_start(16'd5678, e0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_bcd",  bus.bcd_out, 16'h0000);
    check("arst_busy", bus.busy,    1'b0);
    check("arst_done", bus.done,    1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) bc++;
    end
    check("arst_no_done", bc, 0);
    $display("async reset mid-conversion -> bcd=%h", bus.bcd_out);

    pulse_start(16'd5678, e0);
    wait_done(at, bc);
    check("post_rst_lat", at - e0, 17);
    check("post_rst_bcd", bus.bcd_out, 16'h5678);
    $display("post-reset 5678 -> bcd=%h", bus.bcd_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
